fifo_stream_reader: RTL and testbench

Drain-side controller for the `synch_fifo` block. It watches the FIFO's registered `empty` flag and issues `read_en` pulses, accounting for the one-cycle registered SRAM read latency. Returned words land in a 3-entry output buffer and are presented on a valid/ready stream to downstream logic. The FIFO is never over-read, and there is no combinational path from `m_ready` to `fifo_read_en`.

---
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 tb/tb_fifo_stream_reader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drain-side controller for synch_fifo: issues reads against the registered empty flag,
// absorbs the one-cycle read latency in a 3-entry buffer and presents a valid/ready stream.
module fifo_stream_reader #(
  parameter int unsigned FIFO_PTR   = 3,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [FIFO_WIDTH-1:0] fifo_read_data,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      words_out,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int unsigned Depth = 3;

  if (FIFO_PTR == 0) begin : g_ptr_check
    $error("FIFO_PTR must be non-zero");
  end

  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [FIFO_WIDTH-1:0] buf_q [Depth];
  logic [CNT_W-1:0]      words_out_q, words_out_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every word already requested; m_ready is deliberately absent here.
  assign fifo_read_en = en & ~flush & ~fifo_empty &
                        (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[head_q];
  assign words_out = words_out_q;
  assign drop_cnt  = drop_cnt_q;

  assign capture = inflight_q & ~flush;
  assign pop     = m_valid & m_ready & ~flush;

  always_comb begin
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    words_out_d = words_out_q;
    drop_cnt_d  = drop_cnt_q;
    if (flush) begin
      occ_d      = 2'd0;
      head_d     = 2'd0;
      tail_d     = 2'd0;
      drop_cnt_d = drop_cnt_q + CNT_W'(occ_q) + CNT_W'(inflight_q);
    end else begin
      if (capture) begin
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d      = ptr_inc(head_q);
        words_out_d = words_out_q + CNT_W'(1);
      end
      if (capture && !pop) begin
        occ_d = occ_q + 2'd1;
      end else if (!capture && pop) begin
        occ_d = occ_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= 2'd0;
      tail_q      <= 2'd0;
      words_out_q <= '0;
      drop_cnt_q  <= '0;
      buf_q       <= '{default: '0};
    end else begin
      inflight_q  <= fifo_read_en;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      words_out_q <= words_out_d;
      drop_cnt_q  <= drop_cnt_d;
      if (capture) begin
        buf_q[tail_q] <= fifo_read_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a scoreboard tracks
// every word read from the FIFO until it is delivered or discarded.
module tb_fifo_stream_reader;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_read_data = '0;
  logic         fifo_read_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [15:0]  words_out;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] wr_q[$];  // words waiting to be written into the FIFO
  logic [W-1:0] fq[$];    // FIFO contents
  logic [W-1:0] hold[$];  // words read out of the FIFO, not yet delivered or dropped
  logic [W-1:0] got[$];   // words collected by directed sequences

  typedef struct {
    logic         wr;
    logic [W-1:0] wdata;
    logic         exp_ren;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .FIFO_PTR  (3),
    .FIFO_WIDTH(W),
    .CNT_W     (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .fifo_read_en  (fifo_read_en),
    .fifo_read_data(fifo_read_data),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .words_out     (words_out),
    .drop_cnt      (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Depth-8 synchronous FIFO with registered empty and registered read data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      hold.delete();
      wr_q.delete();
      fifo_empty     <= 1'b1;
      fifo_read_data <= '0;
    end else begin
      if (fifo_read_en && fq.size() != 0) begin
        fifo_read_data <= fq[0];
        hold.push_back(fq[0]);
        void'(fq.pop_front());
      end
      if (wr_q.size() != 0 && fq.size() < 8) begin
        fq.push_back(wr_q.pop_front());
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard: in-order delivery, counters, stall stability, no over-read, bounded outstanding.
  initial begin
    logic [15:0]  exp_words;
    logic [15:0]  exp_drop;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    exp_words  = '0;
    exp_drop   = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_words  = '0;
        exp_drop   = '0;
        prev_stall = 1'b0;
      end else begin
        check("words_out", 32'(words_out), 32'(exp_words));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("no_over_read", 32'(fifo_read_en & fifo_empty), 32'(0));
        check("outstanding_le_3", 32'(hold.size() <= 3), 32'(1));
        if (prev_stall) check("stall_stable", {m_valid, m_data}, {1'b1, prev_data});
        if (m_valid && m_ready && !flush) begin
          check("pop_has_word", 32'(hold.size() != 0), 32'(1));
          if (hold.size() != 0) begin
            check("stream_order", 32'(m_data), 32'(hold[0]));
            void'(hold.pop_front());
          end
          exp_words = exp_words + 16'd1;
        end
        if (flush) begin
          exp_drop = exp_drop + 16'(hold.size());
          hold.delete();
        end
        prev_stall = m_valid && !m_ready && !flush;
        prev_data  = m_data;
      end
    end
  end

  task automatic collect(input int n, input int budget, input bit alt);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      if (alt) m_ready = ~m_ready;
      @(negedge clk);
      if (m_valid && m_ready && !flush) got.push_back(m_data);
      c++;
    end
  endtask

  task automatic expect_got(input string name, input logic [W-1:0] base, input int n);
    check({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check(name, 32'(got[i]), 32'(base + W'(i)));
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   pulses;
    int   n;
    vecs[0] = '{wr: 1'b1, wdata: 16'h1234, exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 16'h0};
    vecs[1] = '{wr: 1'b0, wdata: 16'h0,    exp_ren: 1'b1, exp_valid: 1'b0, exp_data: 16'h0};
    vecs[2] = '{wr: 1'b0, wdata: 16'h0,    exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 16'h0};
    vecs[3] = '{wr: 1'b0, wdata: 16'h0,    exp_ren: 1'b0, exp_valid: 1'b1, exp_data: 16'h1234};
    vecs[4] = '{wr: 1'b0, wdata: 16'h0,    exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 16'h0};
    vecs[5] = '{wr: 1'b0, wdata: 16'h0,    exp_ren: 1'b0, exp_valid: 1'b0, exp_data: 16'h0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_words_out", 32'(words_out), 32'(0));
    check("rst_drop_cnt", 32'(drop_cnt), 32'(0));
    check("rst_read_en", 32'(fifo_read_en), 32'(0));
    rst_n   = 1'b1;
    en      = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);

    // Single word: write in cycle 0, read in cycle 1, valid in cycle 3.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (vecs[i].wr) wr_q.push_back(vecs[i].wdata);
      @(negedge clk);
      check("tbl_read_en", 32'(fifo_read_en), 32'(vecs[i].exp_ren));
      check("tbl_valid", 32'(m_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check("tbl_data", 32'(m_data), 32'(vecs[i].exp_data));
    end
    check("single_words_out", 32'(words_out), 32'(1));

    // Streaming: 8 back-to-back words, no bubbles.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) wr_q.push_back(W'(i));
    @(negedge clk);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 8; k++) begin
      check("stream_word", {m_valid, m_data}, {1'b1, W'(k)});
      @(negedge clk);
    end
    check("stream_words_out", 32'(words_out), 32'(9));

    // Backpressure: 6 words, 10 stalled cycles, then release.
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_q.push_back(16'h0100 + W'(i));
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_read_en) pulses++;
      if (c >= 3) check("bp_hold_word0", {m_valid, m_data}, {1'b1, 16'h0100});
    end
    check("bp_read_pulses", 32'(pulses), 32'(3));
    got.delete();
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("resume_first_no_read", 32'(fifo_read_en), 32'(0));
    if (m_valid) got.push_back(m_data);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("resume_next_read", 32'(fifo_read_en), 32'(1));
    if (m_valid) got.push_back(m_data);
    collect(6, 40, 1'b0);
    expect_got("bp_deliver", 16'h0100, 6);
    @(negedge clk);
    check("bp_words_out", 32'(words_out), 32'(15));

    // Alternating ready over 16 words.
    got.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) wr_q.push_back(16'h0200 + W'(i));
    collect(16, 150, 1'b1);
    expect_got("alt_deliver", 16'h0200, 16);
    m_ready = 1'b1;
    @(negedge clk);
    check("alt_words_out", 32'(words_out), 32'(31));

    // Flush with a full buffer; ready high in the flush cycle must not count a pop.
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_q.push_back(16'h0300 + W'(i));
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    flush   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid_low", 32'(m_valid), 32'(0));
    check("flush_drop_cnt", 32'(drop_cnt), 32'(3));
    check("flush_words_out", 32'(words_out), 32'(31));
    got.delete();
    collect(3, 30, 1'b0);
    expect_got("flush_rest", 16'h0303, 3);
    @(negedge clk);
    check("flush_after_words", 32'(words_out), 32'(34));

    // Drop en with one word in flight.
    got.delete();
    @(posedge clk);
    #1;
    wr_q.push_back(16'h0400);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("en_read_issued", 32'(fifo_read_en), 32'(1));
    @(posedge clk);
    #1;
    en = 1'b0;
    wr_q.push_back(16'h0401);
    collect(1, 10, 1'b0);
    expect_got("en_inflight", 16'h0400, 1);
    repeat (4) begin
      @(negedge clk);
      check("en_off_no_read", 32'(fifo_read_en), 32'(0));
    end
    got.delete();
    @(posedge clk);
    #1;
    en = 1'b1;
    collect(1, 10, 1'b0);
    expect_got("en_resume", 16'h0401, 1);
    @(negedge clk);
    check("en_words_out", 32'(words_out), 32'(36));

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr_q.push_back(16'h0500 + W'(i));
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 32'(0));
    check("arst_words_out", 32'(words_out), 32'(0));
    check("arst_drop_cnt", 32'(drop_cnt), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {m_valid, fifo_read_en}, 32'(0));
    end

    // Random traffic, enable, ready and flush against the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      en      = ($urandom_range(0, 9) != 0);
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1 && wr_q.size() < 4) wr_q.push_back(W'($urandom));
    end
    @(posedge clk);
    #1;
    en      = 1'b1;
    m_ready = 1'b1;
    flush   = 1'b0;
    repeat (40) @(negedge clk);
    check("drain_valid_low", 32'(m_valid), 32'(0));
    check("drain_hold_empty", 32'(hold.size()), 32'(0));
    check("drain_fifo_empty", 32'(fq.size() + wr_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
